scanout_timing: RTL
===================

Name: scanout_timing

Overview:
- Display-side consumer of the framebuffer dpram read port.
- Generates VGA 640x480@60 raster timing and produces framebuffer read coordinates, 2x upscaled from the 320x240 framebuffer.
- Realigns the returned RGB565 pixel with delayed hsync/vsync/data-enable for the video output pins.
- Runs entirely in the display clock domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 1, coordinate downscale; fb coordinate = raster coordinate >> SCALE_SHIFT
- FB_WIDTH, 320, framebuffer width
- FB_HEIGHT, 240, framebuffer height
- RD_LATENCY, 1, framebuffer read latency in clocks (address to data)
- SYNC_POL, 0, active level of hsync/vsync

Ports:
- clk  in  1  display clock; all logic on rising edge
- rst  in  1  synchronous active-low reset
- fb_x  out  $clog2(FB_WIDTH)  framebuffer read x
- fb_y  out  $clog2(FB_HEIGHT)  framebuffer read y
- fb_rd_en  out  1  read address valid (active region)
- pixel_in  in  16  RGB565 data from framebuffer, RD_LATENCY clocks after address
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- vid_de  out  1  data enable
- vid_pixel  out  16  RGB565 output; 0 when vid_de=0
- frame_start  out  1  one-clock pulse coincident with the first visible pixel of a frame on vid_*

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and itself wraps to 0 after V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync regions: hsync active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. Active level = SYNC_POL.
- Stage A (1 clk): counter state (h,v) in cycle n is registered into fb_x = h>>SCALE_SHIFT, fb_y = v>>SCALE_SHIFT and fb_rd_en = active, valid in cycle n+1.
  - Outside the active region, fb_x/fb_y hold their last value and fb_rd_en = 0.
  - fb_x/fb_y never exceed FB_WIDTH-1 / FB_HEIGHT-1.
- Stage B: active, hsync, vsync and first-pixel flags pass through a RD_LATENCY-deep shift register.
- Stage C (1 clk): vid_pixel <= delayed_de ? pixel_in : 0; vid_de, vid_hsync, vid_vsync and frame_start are registered alongside.
- Total latency: counter state in cycle n appears on vid_* in cycle n+2+RD_LATENCY (3 at default). Sync, de and pixel are always mutually aligned.
- frame_start is asserted for exactly one clock per frame, when vid_* carries (h=0, v=0).
- Reset (rst=0 at a clock edge), including mid-frame:
  - h_cnt = v_cnt = 0, all pipeline stages cleared.
  - fb_x = fb_y = 0, fb_rd_en = 0.
  - vid_de = 0, vid_pixel = 0, frame_start = 0; vid_hsync = vid_vsync = ~SYNC_POL (inactive).
- Release: first clock with rst=1 starts counting from (0,0). vid_de first rises 2+RD_LATENCY clocks after release, together with frame_start.
- Counter and internal widths use $clog2(H_TOTAL) and $clog2(V_TOTAL). No truncation on the wrap compare.

Test Plan:
- Reset/release: hold rst=0 for 5 clocks -> vid_de=0, vid_pixel=0, hsync=vsync=1, fb_rd_en=0. Release -> frame_start and vid_de rise together exactly 3 clocks later.
- Line/frame timing: run 2 frames -> vid_de high 640 clocks per line; hsync low for 96 clocks starting 656 clocks after de rises; line period 800; vsync low for 2 lines (1600 clocks); frame_start interval 420000 clocks.
- Scaling: sample fb_x/fb_y while fb_rd_en=1 -> h=0,1 give fb_x=0; h=2 gives 1; h=639 gives 319; lines 478 and 479 give fb_y=239; fb_x never reaches 320.
- Alignment: model RAM with latency 1 returning pixel_in = {fb_y[7:0], fb_x[7:0]} -> at each vid_de cycle, vid_pixel equals the expected value for the raster position. During blanking vid_pixel=0 even with pixel_in=16'hFFFF.
- Mid-frame reset: assert rst=0 for 1 clock at (h=300, v=100) -> next clock all outputs at reset values. Timing restarts from (0,0) and frame_start recurs 3 clocks after release.
- RD_LATENCY=2 build: repeat the alignment test -> first vid_de 4 clocks after release and pixels still correctly aligned.

Source files
------------

// File: rtl/scanout_if.sv
// Bundle for the scanout block: framebuffer read port on one side, video
// output pins on the other. The block drives the master modport.
interface scanout_if #(
   parameter int X_W = 9,
   parameter int Y_W = 8
);
   // fb_rd_en qualifies fb_x/fb_y for one clock. There is no ready: the
   // memory accepts every request and returns pixel_in a fixed latency later.
   logic [X_W-1:0] fb_x;
   logic [Y_W-1:0] fb_y;
   logic           fb_rd_en;
   logic [15:0]    pixel_in;
   logic           vid_hsync;
   logic           vid_vsync;
   logic           vid_de;
   logic [15:0]    vid_pixel;
   logic           frame_start;

   modport master (
      output fb_x, fb_y, fb_rd_en,
      input  pixel_in,
      output vid_hsync, vid_vsync, vid_de, vid_pixel, frame_start
   );

   modport slave (
      input  fb_x, fb_y, fb_rd_en,
      output pixel_in,
      input  vid_hsync, vid_vsync, vid_de, vid_pixel, frame_start
   );
endinterface

// File: rtl/scanout_timing.sv
// VGA raster generator that reads a downscaled framebuffer and realigns the
// returned pixel with sync/de so all video pins change on the same clock.
module scanout_timing #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter int   SCALE_SHIFT = 1,
   parameter int   FB_WIDTH    = 320,
   parameter int   FB_HEIGHT   = 240,
   parameter int   RD_LATENCY  = 1,
   parameter logic SYNC_POL    = 1'b0
) (
   input  logic      clk,
   input  logic      rst,
   scanout_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int XW      = $clog2(FB_WIDTH);
   localparam int YW      = $clog2(FB_HEIGHT);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [HW-1:0] X_MAX    = HW'(FB_WIDTH - 1);
   localparam logic [VW-1:0] Y_MAX    = VW'(FB_HEIGHT - 1);

   // Bit positions inside the per-pixel flag bundle carried down the pipe.
   localparam int F_DE    = 0;
   localparam int F_HS    = 1;
   localparam int F_VS    = 2;
   localparam int F_FIRST = 3;

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          h_wrap, v_wrap;
   logic          active, hs_act, vs_act, first_pix;
   logic [HW-1:0] x_scaled;
   logic [VW-1:0] y_scaled;

   logic [XW-1:0] fb_x_q, fb_x_d;
   logic [YW-1:0] fb_y_q, fb_y_d;
   logic [3:0]    flags_a_q, flags_a_d;

   logic [3:0]    dly_q [RD_LATENCY];
   logic [3:0]    dly_d [RD_LATENCY];
   logic [3:0]    flags_b;

   logic [15:0]   vid_pixel_q, vid_pixel_d;
   logic          vid_de_q, vid_de_d;
   logic          vid_hsync_q, vid_hsync_d;
   logic          vid_vsync_q, vid_vsync_d;
   logic          frame_start_q, frame_start_d;

   // Raster counters: h wraps every line, v advances on each h wrap.
   always_comb begin
      h_wrap  = (h_cnt_q == H_LAST);
      v_wrap  = (v_cnt_q == V_LAST);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      end
   end

   always_comb begin
      active    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
      hs_act    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      vs_act    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      first_pix = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   // Stage A: address generation; coordinates hold through blanking and are
   // clamped so a mismatched parameter set cannot address past the buffer.
   always_comb begin
      x_scaled  = h_cnt_q >> SCALE_SHIFT;
      y_scaled  = v_cnt_q >> SCALE_SHIFT;
      fb_x_d    = fb_x_q;
      fb_y_d    = fb_y_q;
      if (active) begin
         fb_x_d = (x_scaled > X_MAX) ? XW'(X_MAX) : XW'(x_scaled);
         fb_y_d = (y_scaled > Y_MAX) ? YW'(Y_MAX) : YW'(y_scaled);
      end
      flags_a_d = {first_pix, vs_act, hs_act, active};
   end

   // Stage B: flags wait out the memory read latency.
   always_comb begin
      dly_d[0] = flags_a_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         dly_d[i] = dly_q[i-1];
      end
      flags_b = dly_q[RD_LATENCY-1];
   end

   // Stage C: output register; pixel is forced to black outside de.
   always_comb begin
      vid_de_d      = flags_b[F_DE];
      vid_pixel_d   = flags_b[F_DE] ? bus.pixel_in : 16'h0000;
      vid_hsync_d   = flags_b[F_HS] ? SYNC_POL : ~SYNC_POL;
      vid_vsync_d   = flags_b[F_VS] ? SYNC_POL : ~SYNC_POL;
      frame_start_d = flags_b[F_FIRST];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         fb_x_q        <= '0;
         fb_y_q        <= '0;
         flags_a_q     <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            dly_q[i] <= '0;
         end
         vid_pixel_q   <= '0;
         vid_de_q      <= 1'b0;
         vid_hsync_q   <= ~SYNC_POL;
         vid_vsync_q   <= ~SYNC_POL;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         fb_x_q        <= fb_x_d;
         fb_y_q        <= fb_y_d;
         flags_a_q     <= flags_a_d;
         for (int i = 0; i < RD_LATENCY; i++) begin
            dly_q[i] <= dly_d[i];
         end
         vid_pixel_q   <= vid_pixel_d;
         vid_de_q      <= vid_de_d;
         vid_hsync_q   <= vid_hsync_d;
         vid_vsync_q   <= vid_vsync_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.fb_x        = fb_x_q;
   assign bus.fb_y        = fb_y_q;
   assign bus.fb_rd_en    = flags_a_q[F_DE];
   assign bus.vid_pixel   = vid_pixel_q;
   assign bus.vid_de      = vid_de_q;
   assign bus.vid_hsync   = vid_hsync_q;
   assign bus.vid_vsync   = vid_vsync_q;
   assign bus.frame_start = frame_start_q;
endmodule
